// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and sampling constants for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int         UART_OVS  = 16;
  localparam logic [3:0] SMP_A     = 4'd7;
  localparam logic [3:0] SMP_B     = 4'd8;
  localparam logic [3:0] SMP_C     = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(UART_OVS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversampling tick generator, one pulse every CLK_HZ/(BAUD*OVS) clocks
module uart_baud_tick #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int OVS    = 16
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_Clr || (cnt_q == CNT_LAST)) cnt_d = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Suppressed while clearing so the first tick lands a full period after the edge.
  assign o_Tick = (cnt_q == CNT_LAST) && !i_Clr;

endmodule

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - 16x oversampling UART receiver with majority-vote sampling and break recovery
import uart_pkg::*;

module uart_rx_ovs #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int OVS    = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx,
  output logic       o_Rx_fDone,
  output logic [7:0] o_Rx_Data,
  output logic       o_Rx_fErr,
  output logic       o_Rx_fBusy
);

  rx_state_e  state_q, state_d;
  logic       sync1_q, sync2_q, prev_q;
  logic [3:0] smp_q, smp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       s7_q, s7_d, s8_q, s8_d;
  logic       done_q, done_d, err_q, err_d;
  logic       tick, clr, maj;

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_Clr (clr),
    .o_Tick(tick)
  );

  assign maj = maj3(s7_q, s8_q, sync2_q);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;

    if (tick && (smp_q == SMP_A)) s7_d = sync2_q;
    if (tick && (smp_q == SMP_B)) s8_d = sync2_q;

    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          smp_d   = '0;
          bit_d   = '0;
          clr     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if ((smp_q == SMP_C) && maj)  state_d = IDLE;
          else if (smp_q == TICK_LAST)  state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == SMP_C) shift_d = {maj, shift_q[7:1]};
          if (smp_q == TICK_LAST) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == SMP_C) begin
            if (maj) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              smp_d   = '0;
              state_d = BREAK;
            end
          end
        end
      end
      BREAK: begin
        // smp counts consecutive high ticks; any low sample restarts the count.
        if (tick) begin
          if (sync2_q) begin
            smp_d = smp_q + 4'd1;
            if (smp_q == TICK_LAST) state_d = IDLE;
          end else begin
            smp_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= i_Rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_Rx_fDone = done_q;
  assign o_Rx_fErr  = err_q;
  assign o_Rx_Data  = data_q;
  assign o_Rx_fBusy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - directed bench for uart_rx_ovs at 16 clocks per bit
module tb_uart_rx_ovs;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       done, err, busy;
  logic [7:0] data;

  always #5 clk = ~clk;

  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(16)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Rx      (rx),
    .o_Rx_fDone(done),
    .o_Rx_Data (data),
    .o_Rx_fErr (err),
    .o_Rx_fBusy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         done_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
  int         last_done_cyc = 0, prev_done_cyc = 0;
  logic [7:0] cap_data = 8'h00;
  logic       done_prev = 1'b0, err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      cap_data      <= data;
      prev_done_cyc <= last_done_cyc;
      last_done_cyc <= cyc;
    end
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if ((done === 1'b1) && (err === 1'b1)) overlap_cnt <= overlap_cnt + 1;
    if (((done === 1'b1) && done_prev) || ((err === 1'b1) && err_prev)) wide_cnt <= wide_cnt + 1;
    done_prev <= (done === 1'b1);
    err_prev  <= (err === 1'b1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      rx = v;
      @(negedge clk);
    end
  endtask

  // spike_bit: frame bit index (0 = start) whose clocks 7 and 8 are inverted; -1 for none.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int spike_bit);
    for (int c = 0; c < 160; c++) begin
      automatic int bi = c / 16;
      automatic logic v;
      if (bi == 0)      v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else              v = stop;
      if ((bi == spike_bit) && ((c % 16 == 7) || (c % 16 == 8))) v = ~v;
      rx = v;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         spike;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0;
    vecs[0] = '{8'h3A, 1'b1, -1, 1, 0, 8'h3A};
    vecs[1] = '{8'h00, 1'b1, -1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, -1, 1, 0, 8'hFF};
    vecs[3] = '{8'hB4, 1'b1,  3, 1, 0, 8'hB4};
    vecs[4] = '{8'h66, 1'b1, -1, 1, 0, 8'h66};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err",  err,  0);
    check("reset_data", data, 8'h00);
    rst = 1'b0;
    hold(1'b1, 4);

    // Back-to-back frames, single stop bit, no idle gap.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].spike);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_err",  i), err_cnt - e0,  vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), cap_data,      vecs[i].exp_data);
      if (i == 2) check("b2b_spacing", last_done_cyc - prev_done_cyc, 160);
    end
    hold(1'b1, 20);

    // Short low glitch: false start.
    d0 = done_cnt;
    e0 = err_cnt;
    hold(1'b0, 4);
    check("glitch_busy_high", busy, 1);
    hold(1'b1, 8);
    check("glitch_busy_still", busy, 1);
    hold(1'b1, 1);
    check("glitch_busy_low", busy, 0);
    hold(1'b1, 20);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_err",  err_cnt - e0,  0);

    // Framing error followed by break recovery.
    d0 = done_cnt;
    e0 = err_cnt;
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      automatic logic [7:0] b = 8'h55;
      hold(b[i], 16);
    end
    hold(1'b0, 40);
    check("ferr_pulse",   err_cnt - e0,  1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_data",    data, 8'h66);
    check("ferr_busy",    busy, 1);
    hold(1'b1, 16);
    check("break_busy_15", busy, 1);
    hold(1'b1, 2);
    check("break_busy_low", busy, 0);
    hold(1'b1, 8);
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, -1);
    check("after_break_done", done_cnt - d0, 1);
    check("after_break_data", cap_data, 8'hA5);
    hold(1'b1, 8);

    // Reset in the middle of data bit 4.
    d0 = done_cnt;
    e0 = err_cnt;
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) begin
      automatic logic [7:0] b = 8'hC3;
      hold(b[i], 16);
    end
    hold(1'b0, 8);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    hold(1'b1, 3);
    check("midrst_busy", busy, 0);
    check("midrst_data", data, 8'h00);
    rst = 1'b0;
    hold(1'b1, 24);
    check("midrst_idle", busy, 0);
    check("midrst_no_done", done_cnt - d0, 0);
    send_frame(8'h81, 1'b1, -1);
    hold(1'b1, 4);
    check("midrst_next_done", done_cnt - d0, 1);
    check("midrst_next_data", cap_data, 8'h81);
    check("midrst_no_err", err_cnt - e0, 0);

    check("pulse_overlap", overlap_cnt, 0);
    check("pulse_width",   wide_cnt,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
